// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per retire over a
// request/acknowledge memory port and selects the next PC from jump/branch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic        retire,
  input  logic        jump,
  input  logic        branchBeq,
  input  logic        branchBne,
  input  logic        zero,
  output logic [31:0] instCount,
  output logic [1:0]  dbgState
);

  // Memory handshake: imemReq stays high through every FETCH cycle and a
  // word is taken on any edge where imemReq and imemAck are both 1; the
  // datapath closes EXEC by raising retire for one cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic [31:0] count_q, count_d;
  logic        armed_q;
  logic [31:0] next_pc;
  logic        br_taken;

  assign pcPlus4    = pc_q + 32'd4;
  assign br_taken   = (branchBeq & zero) | (branchBne & ~zero);

  always_comb begin
    next_pc = pcPlus4;
    if (jump)
      next_pc = {pcPlus4[31:28], instr_q[25:0], 2'b00};
    else if (br_taken)
      next_pc = pcPlus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      // armed_q holds IDLE for the release edge so the first request lands
      // two edges after rst_n rises.
      IDLE: if (armed_q) state_d = FETCH;
      FETCH: begin
        if (imemAck) begin
          instr_d = imemData;
          valid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (retire) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      count_q <= 32'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      count_q <= count_d;
      armed_q <= 1'b1;
    end
  end

  assign imemReq    = req_q;
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign opcode     = instr_q[31:26];
  assign instrValid = valid_q;
  assign pc         = pc_q;
  assign instCount  = count_q;
  assign dbgState   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, wait-state fetches, branch/jump
// targets, PC wrap, spurious handshakes and reset during a fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instrValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        retire;
  logic        jump;
  logic        branchBeq;
  logic        branchBne;
  logic        zero;
  logic [31:0] instCount;
  logic [1:0]  dbgState;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_count;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .instr(instr), .opcode(opcode),
    .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4), .retire(retire),
    .jump(jump), .branchBeq(branchBeq), .branchBne(branchBne), .zero(zero),
    .instCount(instCount), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in FETCH: holds off the ack for 'waits' cycles, then acks 'data'.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
    for (int i = 0; i < waits; i++) begin
      check("req_wait", {31'd0, imemReq}, 32'd1);
      check("addr_wait", imemAddr, addr);
      tick();
    end
    check("req", {31'd0, imemReq}, 32'd1);
    check("addr", imemAddr, addr);
    imemAck = 1'b1;
    imemData = data;
    tick();
    imemAck = 1'b0;
    check("valid", {31'd0, instrValid}, 32'd1);
    check("instr", instr, data);
    check("req_exec", {31'd0, imemReq}, 32'd0);
  endtask

  // Called in EXEC: retires with the given decoder/ALU inputs.
  task automatic do_retire(input logic j, input logic beq, input logic bne,
                           input logic z, input logic [31:0] exp_pc);
    jump = j; branchBeq = beq; branchBne = bne; zero = z; retire = 1'b1;
    tick();
    retire = 1'b0; jump = 1'b0; branchBeq = 1'b0; branchBne = 1'b0; zero = 1'b0;
    exp_count = exp_count + 32'd1;
    check("next_pc", pc, exp_pc);
    check("next_addr", imemAddr, exp_pc);
    check("inst_count", instCount, exp_count);
    check("valid_low", {31'd0, instrValid}, 32'd0);
    check("req_next", {31'd0, imemReq}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; imemAck = 1'b1; imemData = 32'h2000_0001;
    retire = 1'b0; jump = 1'b0; branchBeq = 1'b0; branchBne = 1'b0; zero = 1'b0;
    exp_count = 32'd0;

    // Reset and first fetch
    repeat (3) tick();
    check("rst_req", {31'd0, imemReq}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);
    check("rst_valid", {31'd0, instrValid}, 32'd0);
    check("rst_pc4", pcPlus4, 32'h4);
    check("rst_count", instCount, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_edge1_req", {31'd0, imemReq}, 32'd0);
    tick();
    check("rel_edge2_req", {31'd0, imemReq}, 32'd1);
    check("rel_edge2_addr", imemAddr, 32'h0);
    tick();
    imemAck = 1'b0;
    check("first_valid", {31'd0, instrValid}, 32'd1);
    check("first_instr", instr, 32'h2000_0001);
    check("first_opcode", {26'd0, opcode}, 32'h8);

    // Sequential stream with three wait cycles per fetch
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    do_fetch(32'h4, 32'h0000_0020, 3);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h8);
    do_fetch(32'h8, 32'h0000_0024, 3);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'hC);
    do_fetch(32'hC, 32'h0000_0025, 3);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h10);
    check("count_after_4", instCount, 32'd4);

    // beq taken / not taken at 0x40
    do_fetch(32'h10, 32'h0800_0010, 0);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
    do_fetch(32'h40, 32'h1000_FFFE, 0);
    do_retire(1'b0, 1'b1, 1'b0, 1'b1, 32'h3C);
    do_fetch(32'h3C, 32'h0800_0010, 0);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
    do_fetch(32'h40, 32'h1000_FFFE, 0);
    do_retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h44);

    // bne taken at 0x100
    do_fetch(32'h44, 32'h0800_0040, 0);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
    do_fetch(32'h100, 32'h1400_0003, 0);
    do_retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h110);

    // Reset while fetching at 0x20
    do_fetch(32'h110, 32'h0800_0008, 0);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    exp_count = 32'd0;
    check("midrst_req", {31'd0, imemReq}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_count", instCount, 32'd0);
    imemAck = 1'b1;
    tick();
    tick();
    imemAck = 1'b0;
    rst_n = 1'b1;
    tick();
    check("restart_edge1_req", {31'd0, imemReq}, 32'd0);
    tick();
    check("restart_req", {31'd0, imemReq}, 32'd1);
    check("restart_addr", imemAddr, 32'h0);

    // Backward branch from 0 reaches the top word, then wraps sequentially
    do_fetch(32'h0, 32'h1000_FFFE, 0);
    do_retire(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc4", pcPlus4, 32'h0);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 1);
    imemAck = 1'b1;
    imemData = 32'hDEAD_BEEF;
    tick();
    imemAck = 1'b0;
    check("spur_ack_instr", instr, 32'h0);
    check("spur_ack_valid", {31'd0, instrValid}, 32'd1);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("spur_ret_pc", pc, 32'h0);
    check("spur_ret_count", instCount, exp_count);
    check("spur_ret_req", {31'd0, imemReq}, 32'd1);

    // Jump beats a taken beq in the 0x1000_0000 region
    do_fetch(32'h0, 32'h0BFF_FFFF, 0);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC);
    do_fetch(32'h0FFF_FFFC, 32'h0000_0000, 0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000);
    do_fetch(32'h1000_0000, 32'h0800_0040, 0);
    do_retire(1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
